// File: rtl/rmt_ingress_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rmt_arb_pkg
// Shared definitions for the RMT ingress round-robin arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE = 1'b0, BUSY = 1'b1)
//   - default data / tuser / counter widths
//   - rr_pick()   : rotating-priority search used by rr_priority_pick
// -----------------------------------------------------------------------------
package rmt_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int DEF_CNT_WIDTH   = 32;

  // Upper bound on requesters; rr_pick works on a zero-padded vector of this size.
  localparam int MAX_PORTS = 8;
  localparam int MAX_ID_W  = 3;

  // Returns the first requesting port after 'last' (wrapping modulo nports).
  // The scan runs from the farthest position toward the nearest one so the
  // final overwrite is the highest-priority requester. With no request the
  // value of 'last' is returned; callers qualify it with |req.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] req,
                                 input int                   last,
                                 input int                   nports);
    int idx;
    int pick;
    pick = last;
    for (int i = nports; i >= 1; i--) begin
      idx = (last + i) % nports;
      if (req[idx[MAX_ID_W-1:0]]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating priority encoder.
// Ports:
//   req_i   [NUM_PORTS]     qualified requests (valid & enabled)
//   last_i  [PORT_ID_WIDTH] port granted most recently; it gets lowest priority
//   valid_o                 at least one request present
//   id_o    [PORT_ID_WIDTH] winning port (meaningful only when valid_o = 1)
// -----------------------------------------------------------------------------
module rr_priority_pick
  import rmt_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]     req_i,
  input  logic [PORT_ID_WIDTH-1:0] last_i,
  output logic                     valid_o,
  output logic [PORT_ID_WIDTH-1:0] id_o
);

  // Rotating-priority selection starting just after the last grant.
  always_comb begin
    valid_o = |req_i;
    id_o    = PORT_ID_WIDTH'(rr_pick(MAX_PORTS'(req_i), int'(last_i), NUM_PORTS));
  end

endmodule

// File: rtl/rmt_ingress_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rmt_ingress_rr_arbiter
// Packet-granular round-robin arbiter sharing the RMT pipeline ingress between
// NUM_PORTS AXI-Stream sources. A grant is held from the first beat until the
// tlast beat is accepted, so packets never interleave. The datapath is a
// zero-latency mux; only arbitration state is registered.
// Ports:
//   clk, aresetn                 clock, asynchronous active-low reset
//   s_axis_*  [NUM_PORTS slices] per-port AXIS inputs, s_axis_tready out
//   m_axis_*                     muxed AXIS output toward rmt_wrapper
//   port_en   [NUM_PORTS]        1 = port may win arbitration
//   grant_id                     port currently driving m_axis
//   pkt_cnt   [NUM_PORTS slices] accepted-packet counters (wrapping)
// -----------------------------------------------------------------------------
module rmt_ingress_rr_arbiter
  import rmt_arb_pkg::*;
#(
  parameter int NUM_PORTS            = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int PORT_ID_WIDTH        = 2,
  parameter int CNT_WIDTH            = DEF_CNT_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  input  logic [NUM_PORTS-1:0]                        port_en,
  output logic [PORT_ID_WIDTH-1:0]                    grant_id,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]              pkt_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  arb_state_e                          state_q, state_d;
  logic [PORT_ID_WIDTH-1:0]            last_grant_q, last_grant_d;
  logic [PORT_ID_WIDTH-1:0]            locked_id_q, locked_id_d;
  logic [PORT_ID_WIDTH-1:0]            grant_q, grant_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  logic                                cand_valid_s;
  logic [PORT_ID_WIDTH-1:0]            cand_id_s;
  logic                                act_s;
  logic [PORT_ID_WIDTH-1:0]            sel_s;
  logic                                done_s;

  rr_priority_pick #(
    .NUM_PORTS     (NUM_PORTS),
    .PORT_ID_WIDTH (PORT_ID_WIDTH)
  ) u_pick (
    .req_i   (s_axis_tvalid & port_en),
    .last_i  (last_grant_q),
    .valid_o (cand_valid_s),
    .id_o    (cand_id_s)
  );

  // Source selection and zero-latency AXIS mux. aresetn gates the handshake
  // so both sides go quiet the moment reset asserts, not at the next edge.
  always_comb begin
    act_s = 1'b0;
    sel_s = locked_id_q;
    case (state_q)
      ST_IDLE: begin
        act_s = aresetn & cand_valid_s;
        sel_s = cand_id_s;
      end
      ST_BUSY: begin
        act_s = aresetn;
        sel_s = locked_id_q;
      end
      default: begin
        act_s = 1'b0;
        sel_s = locked_id_q;
      end
    endcase

    m_axis_tdata  = s_axis_tdata[int'(sel_s)*DW +: DW];
    m_axis_tkeep  = s_axis_tkeep[int'(sel_s)*KW +: KW];
    m_axis_tuser  = s_axis_tuser[int'(sel_s)*UW +: UW];
    m_axis_tlast  = s_axis_tlast[sel_s];
    m_axis_tvalid = act_s & s_axis_tvalid[sel_s];

    s_axis_tready = '0;
    if (act_s) begin
      s_axis_tready[sel_s] = m_axis_tready;
    end else begin
      s_axis_tready = '0;
    end

    if (act_s) begin
      grant_id = sel_s;
    end else begin
      grant_id = grant_q;
    end
  end

  // Next-state: packet lock/unlock, round-robin pointer and packet counters.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    locked_id_d  = locked_id_q;
    grant_d      = grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    done_s       = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    if (act_s) begin
      grant_d = sel_s;
    end else begin
      grant_d = grant_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (act_s) begin
          // A single-beat packet accepted on the spot never needs the lock;
          // anything else (multi-beat or stalled) pins the winner.
          if (done_s) begin
            last_grant_d = sel_s;
          end else begin
            state_d     = ST_BUSY;
            locked_id_d = sel_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_d      = ST_IDLE;
          last_grant_d = locked_id_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done_s) begin
      pkt_cnt_d[sel_s] = pkt_cnt_q[sel_s] + CNT_WIDTH'(1'b1);
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
  end

  // Arbitration state registers; reset leaves port 0 with first priority.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      locked_id_q  <= '0;
      grant_q      <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      locked_id_q  <= locked_id_d;
      grant_q      <= grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_rmt_ingress_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rmt_ingress_rr_arbiter
// Directed test of the ingress round-robin arbiter: fairness order, stall
// stability, port masking, mid-packet mask change, async reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_rmt_ingress_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int CW = 32;

  logic               clk;
  logic               aresetn;
  logic [NP*DW-1:0]   s_axis_tdata;
  logic [NP*KW-1:0]   s_axis_tkeep;
  logic [NP*UW-1:0]   s_axis_tuser;
  logic [NP-1:0]      s_axis_tvalid;
  logic [NP-1:0]      s_axis_tlast;
  logic [NP-1:0]      s_axis_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic [KW-1:0]      m_axis_tkeep;
  logic [UW-1:0]      m_axis_tuser;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready;
  logic [NP-1:0]      port_en;
  logic [1:0]         grant_id;
  logic [NP*CW-1:0]   pkt_cnt;

  int total = 0;
  int bad   = 0;

  // bench-side source state: packet length, beats remaining, beat index
  int plen [NP];
  int rem  [NP];
  int bi   [NP];

  rmt_ingress_rr_arbiter dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .port_en       (port_en),
    .grant_id      (grant_id),
    .pkt_cnt       (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tag8(input int p, input int b);
    return {p[3:0], b[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int p, input int pl, input int npk);
    plen[p] = pl;
    rem[p]  = pl * npk;
    bi[p]   = 0;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      logic [7:0] t;
      t = tag8(p, bi[p]);
      s_axis_tvalid[p]          = (rem[p] > 0);
      s_axis_tlast[p]           = (plen[p] > 0) && ((bi[p] % plen[p]) == plen[p] - 1);
      s_axis_tdata[p*DW +: DW]  = {32{t}};
      s_axis_tkeep[p*KW +: KW]  = {4{t}};
      s_axis_tuser[p*UW +: UW]  = {16{t}};
    end
  endtask

  // capture handshakes, advance through the clock edge, update sources
  task automatic tick();
    logic [NP-1:0] hs;
    hs = s_axis_tready & s_axis_tvalid;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        rem[p]--;
        bi[p]++;
      end
    end
    drive();
  endtask

  task automatic cyc();
    tick();
    #1;
  endtask

  task automatic go();
    drive();
    #1;
  endtask

  task automatic chk_beat(input string tag, input int p, input int b, input logic lst);
    chk({tag, "_valid"}, m_axis_tvalid, 1'b1);
    chk({tag, "_gnt"},   grant_id, p);
    chk({tag, "_data"},  m_axis_tdata, {32{tag8(p, b)}});
    chk({tag, "_user"},  m_axis_tuser, {16{tag8(p, b)}});
    chk({tag, "_keep"},  m_axis_tkeep, {4{tag8(p, b)}});
    chk({tag, "_last"},  m_axis_tlast, lst);
  endtask

  initial begin
    int seq3 [6];
    seq3 = '{0, 1, 3, 0, 1, 3};
    for (int p = 0; p < NP; p++) begin
      plen[p] = 1;
      rem[p]  = 0;
      bi[p]   = 0;
    end
    aresetn       = 1'b1;
    m_axis_tready = 1'b0;
    port_en       = 4'h0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    #2;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", m_axis_tvalid, 1'b0);
    chk("rst_ready", s_axis_tready, 4'h0);
    chk("rst_gnt",   grant_id, 2'd0);
    chk("rst_cnt",   pkt_cnt, 128'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // 1: all ports send one 2-beat packet -> 0,1,2,3 back to back
    port_en       = 4'hF;
    m_axis_tready = 1'b1;
    for (int p = 0; p < NP; p++) load(p, 2, 1);
    go();
    for (int k = 0; k < 8; k++) begin
      chk_beat("t1", k / 2, k % 2, 1'((k % 2) == 1));
      cyc();
    end
    chk("t1_idle", m_axis_tvalid, 1'b0);
    chk("t1_cnt",  pkt_cnt, {32'd1, 32'd1, 32'd1, 32'd1});

    // 2: port 1 stalled mid-packet while port 2 waits
    load(1, 3, 1);
    load(2, 1, 1);
    go();
    chk_beat("t2_b0", 1, 0, 1'b0);
    chk("t2_rdy2_b0", s_axis_tready[2], 1'b0);
    cyc();
    m_axis_tready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_beat("t2_stall", 1, 1, 1'b0);
      chk("t2_rdy2", s_axis_tready[2], 1'b0);
      chk("t2_rdy1", s_axis_tready[1], 1'b0);
      cyc();
    end
    m_axis_tready = 1'b1;
    #1;
    chk_beat("t2_b1", 1, 1, 1'b0);
    cyc();
    chk_beat("t2_b2", 1, 2, 1'b1);
    chk("t2_rdy2_b2", s_axis_tready[2], 1'b0);
    cyc();
    chk_beat("t2_p2", 2, 0, 1'b1);
    cyc();
    chk("t2_idle", m_axis_tvalid, 1'b0);

    // single port-3 packet moves the round-robin pointer to 3
    load(3, 1, 1);
    go();
    chk_beat("t3_pre", 3, 0, 1'b1);
    cyc();
    chk("t3_pre_cnt", pkt_cnt, {32'd2, 32'd2, 32'd2, 32'd1});

    // 3: port 2 masked -> 0,1,3,0,1,3 and port 2 held upstream
    port_en = 4'b1011;
    for (int p = 0; p < NP; p++) load(p, 1, 2);
    go();
    for (int k = 0; k < 6; k++) begin
      chk_beat("t3", seq3[k], k / 3, 1'b1);
      chk("t3_rdy2", s_axis_tready[2], 1'b0);
      cyc();
    end
    chk("t3_held_valid", m_axis_tvalid, 1'b0);
    chk("t3_held_rdy2",  s_axis_tready[2], 1'b0);
    port_en = 4'hF;
    #1;
    chk_beat("t3_p2a", 2, 0, 1'b1);
    cyc();
    chk_beat("t3_p2b", 2, 1, 1'b1);
    cyc();
    chk("t3_cnt", pkt_cnt, {32'd4, 32'd4, 32'd4, 32'd3});

    // 4: port 0 disabled during beat 2 of a 4-beat packet
    load(0, 4, 2);
    go();
    chk_beat("t4_b0", 0, 0, 1'b0);
    cyc();
    port_en = 4'b1110;
    #1;
    chk_beat("t4_b1", 0, 1, 1'b0);
    cyc();
    chk_beat("t4_b2", 0, 2, 1'b0);
    cyc();
    chk_beat("t4_b3", 0, 3, 1'b1);
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("t4_blk_valid", m_axis_tvalid, 1'b0);
      chk("t4_blk_rdy0",  s_axis_tready[0], 1'b0);
      cyc();
    end
    chk("t4_cnt", pkt_cnt, {32'd4, 32'd4, 32'd4, 32'd4});
    rem[0]  = 0;
    port_en = 4'hF;
    go();

    // 5: async reset in the middle of a port-3 packet
    load(3, 3, 1);
    load(0, 1, 1);
    go();
    chk_beat("t5_b0", 3, 0, 1'b0);
    cyc();
    chk_beat("t5_b1", 3, 1, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_valid", m_axis_tvalid, 1'b0);
    chk("t5_rst_ready", s_axis_tready, 4'h0);
    chk("t5_rst_cnt",   pkt_cnt, 128'd0);
    chk("t5_rst_gnt",   grant_id, 2'd0);
    rem[3] = 0;
    go();
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk_beat("t5_p0", 0, 0, 1'b1);
    cyc();
    chk("t5_idle", m_axis_tvalid, 1'b0);
    chk("t5_cnt",  pkt_cnt, 128'd1);

    // 6: counter wrap from all-ones
    force dut.pkt_cnt_q = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    @(posedge clk);
    #1;
    release dut.pkt_cnt_q;
    #1;
    chk("t6_preload", pkt_cnt, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF});
    load(0, 1, 1);
    load(1, 1, 1);
    go();
    chk_beat("t6_p1", 1, 0, 1'b1);
    cyc();
    chk_beat("t6_p0", 0, 0, 1'b1);
    cyc();
    chk("t6_cnt", pkt_cnt, {32'd0, 32'd0, 32'd1, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rmt_ingress_rr_arbiter.md
Name: rmt_ingress_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single RMT pipeline ingress (rmt_wrapper s_axis, 256b data / 128b tuser) among NUM_PORTS tenant AXI-Stream sources.
- Grants one whole packet at a time and holds the grant until tlast is accepted, so packets never interleave.
- Sits directly in front of rmt_wrapper.
- Also keeps per-port accepted-packet counters and a per-port enable mask for the control plane.

Parameters:
- NUM_PORTS, 4, number of requesting AXI-Stream sources (2..8).
- C_S_AXIS_DATA_WIDTH, 256, tdata width per port.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width per port.
- PORT_ID_WIDTH, 2, clog2(NUM_PORTS).
- CNT_WIDTH, 32, per-port packet counter width.

Ports:
- clk  in  1  AXIS clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  per-port data; port i occupies slice i.
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  per-port byte enables.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  per-port metadata.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  data to pipeline.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  byte enables to pipeline.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  metadata to pipeline.
- m_axis_tvalid  out  1  valid to pipeline.
- m_axis_tlast  out  1  last to pipeline.
- m_axis_tready  in  1  pipeline ready.
- port_en  in  NUM_PORTS  1 = port may win arbitration.
- grant_id  out  PORT_ID_WIDTH  port currently driving m_axis.
- pkt_cnt  out  NUM_PORTS*CNT_WIDTH  accepted-packet count per port.

Behaviour:
- Reset (async, aresetn=0) clears all state immediately:
  - state=IDLE, last_grant=NUM_PORTS-1 (so port 0 has first priority), grant_id=0, all pkt_cnt=0.
  - m_axis_tvalid=0, s_axis_tready=0.
  - A packet in flight when reset asserts is abandoned; no recovery beat is emitted.
- Zero-latency path: m_axis_* are muxed combinationally from the selected port; s_axis_tready[sel] = m_axis_tready, all other s_axis_tready = 0.
- State IDLE:
  - Candidate = first port p, scanning last_grant+1, +2, … mod NUM_PORTS, with s_axis_tvalid[p] && port_en[p].
  - No candidate: m_axis_tvalid=0.
  - Candidate found: forwarded this cycle; grant_id=p.
  - Next state:
    - Beat accepted (m_axis_tready=1) with tlast=1: stay IDLE, last_grant<=p, pkt_cnt[p]++.
    - Beat accepted with tlast=0: go to BUSY, locked_id<=p.
    - Beat not accepted (tready=0): go to BUSY, locked_id<=p. Output must not change once valid is asserted (AXIS stability).
- State BUSY:
  - Only locked_id is muxed; other ports see tready=0.
  - port_en changes are ignored until the packet ends.
  - Source valid gaps mid-packet: m_axis_tvalid follows the locked port's tvalid; the grant is held.
  - Accepted beat with tlast=1: go to IDLE, last_grant<=locked_id, pkt_cnt[locked_id]++.
- The first beat must be accepted before the next arbitration; at most one packet completes per cycle.
- pkt_cnt wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- A disabled port keeps tready=0 and its packet is held upstream.
- All ports disabled or idle: output idle, no state change.
- Fairness: back-to-back packets from all ports are served strictly 0,1,2,3,0,… with no idle cycle between packets when m_axis_tready=1.

Decomposition:
- Shared package rmt_arb_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1);
  - function rr_pick(req, last) returning the next port;
  - the default width constants (256/128/32).
- One sub-module is natural: rr_priority_pick, a combinational rotating priority encoder (req, last_grant -> valid, id).
- The mux, FSM and counters stay in the top module.

Test Plan:
1. Ports 0-3 each send one 2-beat packet simultaneously, m_axis_tready=1, port_en=4'hF -> output order ports 0,1,2,3; 8 consecutive valid beats; no interleave; pkt_cnt = 1,1,1,1.
2. Port 1 mid-packet (beat 1 of 3) with port 2 valid; m_axis_tready low for 5 cycles -> tdata/tuser stable, grant_id stays 1, port 2 tready=0 throughout; port 2 granted immediately after port 1's tlast.
3. port_en=4'b1011 with all four ports valid -> port 2 never granted and its s_axis_tready stays 0; sequence 0,1,3,0,1,3.
4. Clear port_en[0] during beat 2 of a 4-beat port-0 packet -> packet completes intact; port 0 not granted again.
5. Assert aresetn=0 mid-packet on port 3 -> m_axis_tvalid drops asynchronously, pkt_cnt all 0; after release, port 0 wins first.
6. Preload traffic so port 0 completes 2^32 packets (or force counter to 32'hFFFFFFFF) then send one more packet -> pkt_cnt[0] = 0.
